// File: rtl/npu_stream_router.sv
// npu_stream_router: routes host packets to one of NUM_CH compute channels by a
// header beat, and merges per-channel result packets back to the host with a
// packet-atomic round-robin arbiter. Ingress and egress run independently.
//
// state  | meaning
// I_HDR  | waiting for a header beat; header is consumed, never forwarded
// I_FWD  | forwarding payload to channel sel_q with zero latency
// I_DROP | header named a nonexistent channel; payload is discarded
// E_ARB  | no grant; picks the next requesting channel from rr_ptr_q
// E_LOCK | result channel gnt_q owns egress until its tlast beat is taken
module npu_stream_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int IRQ_EN     = 1,
  localparam int CH_BITS   = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_tdata,
  output logic [NUM_CH-1:0]            ch_tvalid,
  input  logic [NUM_CH-1:0]            ch_tready,
  output logic [NUM_CH-1:0]            ch_tlast,
  input  logic [NUM_CH*DATA_WIDTH-1:0] res_tdata,
  input  logic [NUM_CH-1:0]            res_tvalid,
  output logic [NUM_CH-1:0]            res_tready,
  input  logic [NUM_CH-1:0]            res_tlast,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [CH_BITS-1:0]           m_axis_tid,
  output logic [31:0]                  status,
  output logic                         interrupt
);

  typedef enum logic [1:0] {I_HDR = 2'd0, I_FWD = 2'd1, I_DROP = 2'd2} in_state_t;
  typedef enum logic {E_ARB = 1'b0, E_LOCK = 1'b1} eg_state_t;

  in_state_t            in_state_q;
  logic [CH_BITS-1:0]   sel_q;
  logic                 err_q;
  logic [7:0]           in_cnt_q, in_cnt_d;

  eg_state_t            eg_state_q;
  logic [CH_BITS-1:0]   gnt_q;
  logic [CH_BITS-1:0]   rr_ptr_q;
  logic [7:0]           out_cnt_q, out_cnt_d;

  logic                 irq_q;

  logic                 s_fire;
  logic [CH_BITS-1:0]   hdr_ch;
  logic                 hdr_ok;
  logic                 hdr_bad;
  logic                 in_done;
  logic                 eg_done;

  logic [2*NUM_CH-1:0]  res_dbl;
  logic [NUM_CH-1:0]    res_rot;
  logic                 arb_any;
  logic [CH_BITS-1:0]   arb_idx;
  int                   arb_sum;

  // Payload is broadcast on every channel; only the selected channel's valid rises.
  assign ch_tdata = {NUM_CH{s_axis_tdata}};

  // Ingress handshake steering; everything held quiet while rst is high.
  always_comb begin
    s_axis_tready = 1'b0;
    ch_tvalid     = '0;
    ch_tlast      = '0;
    if (!rst) begin
      case (in_state_q)
        I_HDR, I_DROP: s_axis_tready = 1'b1;
        I_FWD: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (CH_BITS'(k) == sel_q) begin
              s_axis_tready = ch_tready[k];
              ch_tvalid[k]  = s_axis_tvalid;
              ch_tlast[k]   = s_axis_tlast;
            end
          end
        end
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  assign s_fire   = s_axis_tvalid & s_axis_tready;
  assign hdr_ch   = s_axis_tdata[CH_BITS-1:0];
  assign hdr_ok   = (32'(hdr_ch) < NUM_CH);
  assign hdr_bad  = s_fire && (in_state_q == I_HDR) && !s_axis_tlast && !hdr_ok;
  // Empty packets (header with tlast) and forwarded packets count; dropped ones do not.
  assign in_done  = s_fire && s_axis_tlast && ((in_state_q == I_HDR) || (in_state_q == I_FWD));
  assign in_cnt_d = in_done ? in_cnt_q + 8'd1 : in_cnt_q;

  // Ingress FSM with its packet counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q <= I_HDR;
      sel_q      <= '0;
      err_q      <= 1'b0;
      in_cnt_q   <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
      if (hdr_bad) err_q <= 1'b1;
      case (in_state_q)
        I_HDR: begin
          if (s_fire && !s_axis_tlast) begin
            if (hdr_ok) begin
              sel_q      <= hdr_ch;
              in_state_q <= I_FWD;
            end else begin
              in_state_q <= I_DROP;
            end
          end
        end
        I_FWD, I_DROP: begin
          if (s_fire && s_axis_tlast) in_state_q <= I_HDR;
        end
        default: in_state_q <= I_HDR;
      endcase
    end
  end

  // Round-robin pick: rotate requests so rr_ptr_q lands at bit 0, lowest set bit wins.
  always_comb begin
    res_dbl = {res_tvalid, res_tvalid};
    res_rot = NUM_CH'(res_dbl >> rr_ptr_q);
    arb_any = 1'b0;
    arb_idx = '0;
    arb_sum = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (res_rot[i]) begin
        arb_any = 1'b1;
        arb_sum = int'(rr_ptr_q) + i;
        if (arb_sum >= NUM_CH) arb_sum = arb_sum - NUM_CH;
        arb_idx = CH_BITS'(arb_sum);
      end
    end
  end

  // Egress mux: the granted result stream is passed straight through while locked.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    res_tready    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_BITS'(k) == gnt_q) begin
        m_axis_tdata = res_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast = res_tlast[k];
        if (!rst && (eg_state_q == E_LOCK)) begin
          m_axis_tvalid = res_tvalid[k];
          res_tready[k] = m_axis_tready;
        end
      end
    end
  end

  assign m_axis_tid = gnt_q;
  assign eg_done    = (eg_state_q == E_LOCK) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign out_cnt_d  = eg_done ? out_cnt_q + 8'd1 : out_cnt_q;

  // Egress FSM: grant held for a whole packet, pointer moves past the finished channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      eg_state_q <= E_ARB;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      case (eg_state_q)
        E_ARB: begin
          if (arb_any) begin
            gnt_q      <= arb_idx;
            eg_state_q <= E_LOCK;
          end
        end
        E_LOCK: begin
          if (eg_done) begin
            eg_state_q <= E_ARB;
            rr_ptr_q   <= (gnt_q == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_q + CH_BITS'(1);
          end
        end
        default: eg_state_q <= E_ARB;
      endcase
    end
  end

  // Both events in one cycle still produce a single pulse.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (IRQ_EN != 0) && (hdr_bad || eg_done);
  end

  assign interrupt = irq_q;
  assign status    = {13'd0, (eg_state_q == E_LOCK), (in_state_q != I_HDR), err_q, out_cnt_q, in_cnt_q};

endmodule

// File: tb/tb_npu_stream_router.sv
// Bench for npu_stream_router: a 4-channel instance for routing/egress work and a
// 3-channel instance for the out-of-range header case.
module tb_npu_stream_router;
  localparam int DW  = 32;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]     s_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic [NCH*DW-1:0] ch_tdata;
  logic [NCH-1:0]    ch_tvalid, ch_tready, ch_tlast;
  logic [NCH*DW-1:0] res_tdata;
  logic [NCH-1:0]    res_tvalid, res_tready, res_tlast;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [1:0]        m_tid;
  logic [31:0]       status;
  logic              interrupt;

  logic [DW-1:0]     b_s_tdata;
  logic              b_s_tvalid, b_s_tready, b_s_tlast;
  logic [3*DW-1:0]   b_ch_tdata;
  logic [2:0]        b_ch_tvalid, b_ch_tready, b_ch_tlast;
  logic [3*DW-1:0]   b_res_tdata;
  logic [2:0]        b_res_tvalid, b_res_tready, b_res_tlast;
  logic [DW-1:0]     b_m_tdata;
  logic              b_m_tvalid, b_m_tready, b_m_tlast;
  logic [1:0]        b_m_tid;
  logic [31:0]       b_status;
  logic              b_interrupt;

  npu_stream_router #(.DATA_WIDTH(DW), .NUM_CH(NCH), .IRQ_EN(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_tlast(ch_tlast),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tlast(res_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .status(status), .interrupt(interrupt)
  );

  npu_stream_router #(.DATA_WIDTH(DW), .NUM_CH(3), .IRQ_EN(1)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast),
    .ch_tdata(b_ch_tdata), .ch_tvalid(b_ch_tvalid), .ch_tready(b_ch_tready), .ch_tlast(b_ch_tlast),
    .res_tdata(b_res_tdata), .res_tvalid(b_res_tvalid), .res_tready(b_res_tready), .res_tlast(b_res_tlast),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast),
    .m_axis_tid(b_m_tid), .status(b_status), .interrupt(b_interrupt)
  );

  int total = 0;
  int bad   = 0;
  int irq_a = 0;
  int irq_b = 0;
  int exp_in = 0;
  logic [31:0] salt;

  // Counts high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (interrupt)   irq_a++;
    if (b_interrupt) irq_b++;
  end

  function automatic logic [31:0] pkt_word(input int c, input int p, input int b);
    return salt ^ 32'((c << 16) | (p << 8) | b);
  endfunction

  // First requesting channel at or after ptr, wrapping around.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int i = 0; i < 4; i++)
      if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; res_tvalid = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_in = 0;
  endtask

  // dest: -1 header, -2 dropped payload, >=0 payload routed to that channel.
  task automatic push_beat(input logic [31:0] d, input bit last, input int dest, input bit gap);
    int n;
    bit acc;
    logic [3:0] expv;
    if (gap) begin
      s_tvalid = 1'b0; ch_tready = 4'($urandom);
      @(negedge clk);
      total++; if (ch_tvalid !== 4'b0) begin bad++; $display("FAIL gap_valid got=%b exp=0000", ch_tvalid); end
      @(posedge clk); #1;
    end
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1; acc = 1'b0; n = 0;
    while (!acc && n < 40) begin
      ch_tready = 4'($urandom) | ((n > 8) ? 4'hF : 4'h0);
      @(negedge clk);
      if (dest < 0) begin
        total++; if (s_tready !== 1'b1 || ch_tvalid !== 4'b0) begin
          bad++; $display("FAIL hdr_phase got ready=%b valid=%b exp ready=1 valid=0000", s_tready, ch_tvalid); end
      end else begin
        expv = 4'b1 << dest;
        total++; if (ch_tvalid !== expv) begin bad++; $display("FAIL route_valid got=%b exp=%b", ch_tvalid, expv); end
        total++; if (s_tready !== ch_tready[dest]) begin bad++; $display("FAIL route_ready got=%b exp=%b", s_tready, ch_tready[dest]); end
        total++; if (ch_tdata[dest*DW +: DW] !== d || ch_tlast[dest] !== last) begin
          bad++; $display("FAIL route_data got=%h/%b exp=%h/%b", ch_tdata[dest*DW +: DW], ch_tlast[dest], d, last); end
      end
      total++; if (status[17] !== (dest != -1)) begin bad++; $display("FAIL busy_flag got=%b exp=%b", status[17], (dest != -1)); end
      acc = s_tready; n++;
      @(posedge clk); #1;
    end
    if (!acc) begin total++; bad++; $display("FAIL beat_timeout got=no_accept exp=accept"); end
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int dest, input int len);
    logic [31:0] h;
    h = $urandom; h[1:0] = dest[1:0];
    push_beat(h, len == 0, -1, 1'b0);
    for (int b = 0; b < len; b++) push_beat($urandom, b == len - 1, dest, $urandom_range(0, 3) == 0);
    exp_in++;
    total++; if (status[7:0] !== 8'(exp_in)) begin bad++; $display("FAIL in_cnt got=%0d exp=%0d", status[7:0], 8'(exp_in)); end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h1; s_tlast = 1'b0; ch_tready = 4'hF;
    res_tvalid = 4'hF; res_tlast = 4'hF; res_tdata = '0; m_tready = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_tready); end
    total++; if (ch_tvalid !== 4'b0) begin bad++; $display("FAIL rst_ch_valid got=%b exp=0", ch_tvalid); end
    total++; if (res_tready !== 4'b0) begin bad++; $display("FAIL rst_res_ready got=%b exp=0", res_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_tvalid); end
    total++; if (status !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", status); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", interrupt); end
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0; res_tvalid = '0; m_tready = 1'b0; exp_in = 0;
  endtask

  task automatic test_invalid();
    int base;
    base = irq_b;
    b_ch_tready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      b_s_tdata = (i == 0) ? 32'h3 : $urandom; b_s_tlast = (i == 2); b_s_tvalid = 1'b1;
      @(negedge clk);
      total++; if (b_ch_tvalid !== 3'b0 || b_s_tready !== 1'b1) begin
        bad++; $display("FAIL inv_drop got valid=%b ready=%b exp valid=000 ready=1", b_ch_tvalid, b_s_tready); end
      if (i > 0) begin
        total++; if (b_status[17] !== 1'b1) begin bad++; $display("FAIL inv_busy got=%b exp=1", b_status[17]); end
      end
      @(posedge clk); #1;
    end
    b_s_tvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if (b_status[16] !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", b_status[16]); end
    total++; if (b_status[7:0] !== 8'd0) begin bad++; $display("FAIL inv_in_cnt got=%0d exp=0", b_status[7:0]); end
    total++; if (irq_b - base !== 1) begin bad++; $display("FAIL inv_irq got=%0d exp=1", irq_b - base); end
    // A legal packet afterwards still routes, and the error flag stays set.
    for (int i = 0; i < 2; i++) begin
      b_s_tdata = (i == 0) ? 32'h1 : 32'hCAFE_0001; b_s_tlast = (i == 1); b_s_tvalid = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        total++; if (b_ch_tvalid !== 3'b010 || b_ch_tdata[DW +: DW] !== 32'hCAFE_0001) begin
          bad++; $display("FAIL inv_recover got=%b/%h exp=010/cafe0001", b_ch_tvalid, b_ch_tdata[DW +: DW]); end
      end
      @(posedge clk); #1;
    end
    b_s_tvalid = 1'b0;
    @(negedge clk);
    total++; if (b_status[7:0] !== 8'd1 || b_status[16] !== 1'b1) begin
      bad++; $display("FAIL inv_after got cnt=%0d err=%b exp cnt=1 err=1", b_status[7:0], b_status[16]); end
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    push_beat(32'h2, 1'b0, -1, 1'b0);
    for (int b = 0; b < 3; b++) push_beat($urandom, b == 2, 2, 1'b0);
    exp_in++;
    total++; if (status[7:0] !== 8'd1) begin bad++; $display("FAIL route_in_cnt got=%0d exp=1", status[7:0]); end
  endtask

  task automatic test_random_ingress();
    for (int p = 0; p < 20; p++) send_pkt($urandom_range(0, 3), $urandom_range(0, 4));
  endtask

  task automatic test_empty();
    send_pkt(1, 0);
    @(negedge clk);
    total++; if (status[17] !== 1'b0 || ch_tvalid !== 4'b0) begin
      bad++; $display("FAIL empty_state got busy=%b valid=%b exp busy=0 valid=0000", status[17], ch_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int plen [4][8];
    int pi [4];
    int bi [4];
    int mpi [4];
    int exp_ch [$];
    logic [31:0] exp_d [$];
    bit exp_l [$];
    int ptr, g, n, pkts, base;
    logic [3:0] expr;
    do_reset();
    base = irq_a;
    for (int c = 0; c < 4; c++) begin
      pi[c] = 0; bi[c] = 0; mpi[c] = 0;
      for (int p = 0; p < 8; p++) plen[c][p] = $urandom_range(1, 3);
    end
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      g = rr_pick(4'b1011, ptr);
      for (int b = 0; b < plen[g][mpi[g]]; b++) begin
        exp_ch.push_back(g); exp_d.push_back(pkt_word(g, mpi[g], b)); exp_l.push_back(b == plen[g][mpi[g]] - 1);
      end
      mpi[g]++; ptr = (g + 1) % 4;
    end
    n = 0; pkts = 0;
    while (exp_ch.size() > 0 && n < 300) begin
      m_tready = n[0];
      res_tvalid = 4'b1011;
      for (int c = 0; c < 4; c++) begin
        res_tdata[c*DW +: DW] = pkt_word(c, pi[c], bi[c]);
        res_tlast[c] = (bi[c] == plen[c][pi[c]] - 1);
      end
      @(negedge clk);
      if (n == 0) begin
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_lat0 got=%b exp=0", m_tvalid); end
      end
      if (n == 1) begin
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL bp_lat1 got=%b exp=1", m_tvalid); end
      end
      if (status[18] === 1'b0) begin
        total++; if (m_tvalid !== 1'b0 || res_tready !== 4'b0) begin
          bad++; $display("FAIL bp_arb got valid=%b ready=%b exp 0/0000", m_tvalid, res_tready); end
      end else begin
        expr = 4'(m_tready) << m_tid;
        total++; if (m_tvalid !== 1'b1 || res_tready !== expr) begin
          bad++; $display("FAIL bp_lock got valid=%b ready=%b exp 1/%b", m_tvalid, res_tready, expr); end
      end
      if (m_tvalid && m_tready) begin
        total++; if (m_tid !== 2'(exp_ch[0]) || m_tdata !== exp_d[0] || m_tlast !== exp_l[0]) begin
          bad++; $display("FAIL bp_beat got=%0d/%h/%b exp=%0d/%h/%b", m_tid, m_tdata, m_tlast, exp_ch[0], exp_d[0], exp_l[0]); end
        if (exp_l[0]) begin
          total++; if (status[15:8] !== 8'(pkts)) begin bad++; $display("FAIL bp_out_cnt got=%0d exp=%0d", status[15:8], pkts); end
          pkts++;
        end
        void'(exp_ch.pop_front()); void'(exp_d.pop_front()); void'(exp_l.pop_front());
      end
      for (int c = 0; c < 4; c++) begin
        if (res_tvalid[c] && res_tready[c]) begin
          if (res_tlast[c]) begin pi[c]++; bi[c] = 0; end
          else bi[c]++;
        end
      end
      n++;
      @(posedge clk); #1;
    end
    res_tvalid = '0; m_tready = 1'b0;
    if (exp_ch.size() > 0) begin total++; bad++; $display("FAIL bp_timeout got=%0d_left exp=0_left", exp_ch.size()); end
    repeat (3) @(posedge clk); #1;
    total++; if (status[15:8] !== 8'd4 || status[18] !== 1'b0) begin
      bad++; $display("FAIL bp_final got cnt=%0d lock=%b exp cnt=4 lock=0", status[15:8], status[18]); end
    total++; if (irq_a - base !== 4) begin bad++; $display("FAIL bp_irq got=%0d exp=4", irq_a - base); end
  endtask

  task automatic test_wrap();
    int ptr, g, n, pkts, base;
    bit need;
    logic [3:0] mask;
    do_reset();
    base = irq_a;
    res_tlast = 4'hF;
    for (int c = 0; c < 4; c++) res_tdata[c*DW +: DW] = salt ^ 32'(c * 32'h1111);
    ptr = 0; pkts = 0; n = 0; need = 1'b1; g = 0; mask = 4'h1;
    while (pkts < 256 && n < 3000) begin
      if (need) begin
        mask = 4'($urandom_range(1, 15));
        g = rr_pick(mask, ptr);
        need = 1'b0;
      end
      res_tvalid = mask;
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        total++; if (m_tid !== 2'(g) || m_tdata !== (salt ^ 32'(g * 32'h1111)) || m_tlast !== 1'b1) begin
          bad++; $display("FAIL wrap_beat got=%0d/%h exp=%0d/%h", m_tid, m_tdata, g, salt ^ 32'(g * 32'h1111)); end
        total++; if (status[15:8] !== 8'(pkts)) begin bad++; $display("FAIL wrap_out_cnt got=%0d exp=%0d", status[15:8], 8'(pkts)); end
        pkts++; ptr = (g + 1) % 4; need = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    res_tvalid = '0; m_tready = 1'b0;
    if (pkts < 256) begin total++; bad++; $display("FAIL wrap_timeout got=%0d exp=256", pkts); end
    repeat (3) @(posedge clk); #1;
    total++; if (status[15:8] !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0d exp=0", status[15:8]); end
    total++; if (irq_a - base !== 256) begin bad++; $display("FAIL wrap_irq got=%0d exp=256", irq_a - base); end
  endtask

  task automatic test_reset_mid();
    res_tvalid = 4'b0100; res_tlast = 4'b0000; res_tdata[2*DW +: DW] = 32'h5A5A_0002; m_tready = 1'b0;
    push_beat(32'h0000_0101, 1'b0, -1, 1'b0);
    push_beat($urandom, 1'b0, 1, 1'b0);
    @(negedge clk);
    total++; if (status[18:17] !== 2'b11) begin bad++; $display("FAIL mid_busy got=%b exp=11", status[18:17]); end
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h2; s_tlast = 1'b0; ch_tready = 4'hF; m_tready = 1'b1;
    @(negedge clk);
    total++; if (s_tready !== 1'b0 || ch_tvalid !== 4'b0 || res_tready !== 4'b0 || m_tvalid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_gate got %b/%b/%b/%b exp 0/0000/0000/0", s_tready, ch_tvalid, res_tready, m_tvalid); end
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0; res_tvalid = '0; exp_in = 0;
    @(negedge clk);
    total++; if (status !== 32'h0 || interrupt !== 1'b0) begin
      bad++; $display("FAIL mid_rst_state got status=%h irq=%b exp 0/0", status, interrupt); end
    @(posedge clk); #1;
    send_pkt(3, 1);
  endtask

  initial begin
    salt = $urandom;
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; ch_tready = '0;
    res_tdata = '0; res_tvalid = '0; res_tlast = '0; m_tready = 1'b0;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_ch_tready = '0;
    b_res_tdata = '0; b_res_tvalid = '0; b_res_tlast = '0; b_m_tready = 1'b0;
    test_reset();
    test_invalid();
    test_routing();
    test_random_ingress();
    test_empty();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    @(negedge clk);
    total++; if (status[16] !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", status[16]); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
